// File: rtl/fifo_stim_pkg.sv
// Shared constants for the FIFO stimulus generator: state and phase
// encodings, LFSR taps, default seed and the LFSR step function.
package fifo_stim_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FILL  = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] MIX   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_FILL  = 2'd1;
    localparam logic [1:0] PH_DRAIN = 2'd2;
    localparam logic [1:0] PH_MIX   = 2'd3;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Fibonacci step, taps 16,14,13,11 (bits 15,13,12,10).
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

    function automatic logic [1:0] phase_of(input logic [2:0] st);
        logic [1:0] ph;
        ph = PH_IDLE;
        if (st == FILL)  ph = PH_FILL;
        if (st == DRAIN) ph = PH_DRAIN;
        if (st == MIX)   ph = PH_MIX;
        return ph;
    endfunction

endpackage

// File: rtl/fifo_stim_gen_lfsr16.sv
// 16-bit Fibonacci LFSR; loads seed on reset, steps when enable is high.
// Ports: clk, reset (async high), enable, seed[15:0], q[15:0].
module lfsr16
    import fifo_stim_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= seed;
        end else if (enable) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/fifo_stim_gen.sv
// Traffic generator for a W-bit S-deep FIFO: overfill, overdrain, random mix.
// Ports: clk, reset (async high), iSTART, iFULL, iEMPTY in; oENQ, oDEQ, oD,
// oPHASE, oBUSY, oDONE out (all registered).
// Build option: define FIFO_STIM_SIMUL_EN to allow simultaneous enq/deq in MIX.
module fifo_stim_gen
    import fifo_stim_pkg::*;
#(
    parameter int          W       = 8,
    parameter int          S       = 16,
    parameter logic [15:0] SEED    = DEFAULT_SEED,
    parameter int          MIX_LEN = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         iSTART,
    input  logic         iFULL,
    input  logic         iEMPTY,
    output logic         oENQ,
    output logic         oDEQ,
    output logic [W-1:0] oD,
    output logic [1:0]   oPHASE,
    output logic         oBUSY,
    output logic         oDONE
);

    localparam int FILL_LEN = S + 2;
    localparam int MAX_LEN  = (FILL_LEN > MIX_LEN) ? FILL_LEN : MIX_LEN;
    localparam int CW       = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] FILL_LAST = CW'(FILL_LEN - 1);
    localparam logic [CW-1:0] MIX_LAST  = CW'(MIX_LEN - 1);
    localparam logic [CW-1:0] TAIL_CNT  = CW'(S);

    logic [2:0]    state;
    logic [2:0]    nstate;
    logic [CW-1:0] cnt;
    logic [15:0]   lfsr_q;
    logic [15:0]   lfsr_n;
    logic          lfsr_en;
    logic          enq_n;
    logic          deq_n;
    logic          drain_tail;
    logic          err;

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (iSTART) nstate = FILL;
            FILL:    if (cnt == FILL_LAST) nstate = DRAIN;
            DRAIN:   if (cnt == FILL_LAST) nstate = MIX;
            MIX:     if (cnt == MIX_LAST) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // The LFSR steps on every edge that lands in a MIX cycle, so the
    // strobes of that cycle come from the freshly stepped value.
    assign lfsr_en = (nstate == MIX);
    assign lfsr_n  = lfsr_step(lfsr_q);

    lfsr16 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (lfsr_en),
        .seed   (SEED),
        .q      (lfsr_q)
    );

    always_comb begin
        enq_n = 1'b0;
        deq_n = 1'b0;
        unique case (1'b1)
            nstate == FILL:  enq_n = 1'b1;
            nstate == DRAIN: deq_n = 1'b1;
            nstate == MIX: begin
`ifdef FIFO_STIM_SIMUL_EN
                if (lfsr_n[1:0] == 2'b11) begin
                    enq_n = 1'b1;
                    deq_n = 1'b1;
                end else begin
                    enq_n = lfsr_n[0];
                    deq_n = ~lfsr_n[0];
                end
`else
                enq_n = lfsr_n[0];
                deq_n = ~lfsr_n[0];
`endif
            end
            default: ;
        endcase
    end

    // The last two DRAIN cycles pop an empty FIFO on purpose.
    assign drain_tail = (state == DRAIN) && (cnt >= TAIL_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            oENQ   <= 1'b0;
            oDEQ   <= 1'b0;
            oD     <= '0;
            oPHASE <= PH_IDLE;
            oBUSY  <= 1'b0;
            oDONE  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= nstate;
            oENQ   <= enq_n;
            oDEQ   <= deq_n;
            oPHASE <= phase_of(nstate);
            oBUSY  <= (nstate == FILL) || (nstate == DRAIN) ||
                      (nstate == MIX);
            oDONE  <= (nstate == DONE);
            if (nstate != state || state == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            // Rejected writes leave the counter alone: no data gaps.
            if (oENQ && !iFULL) begin
                oD <= oD + W'(1);
            end
            if (state == IDLE && nstate == FILL) begin
                err <= 1'b0;
            end else if (oDEQ && iEMPTY && !drain_tail) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stim_gen.sv
// Self-checking bench for fifo_stim_gen with an in-bench FIFO model.
// Expected traffic comes from a position schedule and an arithmetic LFSR.
module tb_fifo_stim_gen;

    localparam int          W       = 8;
    localparam int          S       = 16;
    localparam int          MIX_LEN = 300;
    localparam int          FL      = S + 2;
    localparam int          RUN_LEN = 2 * FL + MIX_LEN;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic         clk = 1'b0;
    logic         reset;
    logic         iSTART;
    logic         iFULL;
    logic         iEMPTY;
    logic         oENQ;
    logic         oDEQ;
    logic [W-1:0] oD;
    logic [1:0]   oPHASE;
    logic         oBUSY;
    logic         oDONE;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          exp_d;
    int          exp_rd;
    int          sim_cnt;
    int          done_cnt;
    logic [15:0] ref_lfsr;
    int          q[$];

    fifo_stim_gen #(
        .W       (W),
        .S       (S),
        .SEED    (SEED),
        .MIX_LEN (MIX_LEN)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .iSTART (iSTART),
        .iFULL  (iFULL),
        .iEMPTY (iEMPTY),
        .oENQ   (oENQ),
        .oDEQ   (oDEQ),
        .oD     (oD),
        .oPHASE (oPHASE),
        .oBUSY  (oBUSY),
        .oDONE  (oDONE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        int b;
        int x;
        x = int'(v);
        b = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
        return 16'(((x << 1) | b) & 16'hFFFF);
    endfunction

    task automatic cyc(input bit e_enq, input bit e_deq, input int e_ph,
                       input bit e_busy, input bit e_done);
        bit           pe;
        bit           pd;
        logic [W-1:0] pdat;
        int           v;
        @(negedge clk);
        chk("oENQ", 32'(oENQ), 32'(e_enq));
        chk("oDEQ", 32'(oDEQ), 32'(e_deq));
        chk("oD", 32'(oD), 32'(exp_d));
        chk("oPHASE", 32'(oPHASE), 32'(e_ph));
        chk("oBUSY", 32'(oBUSY), 32'(e_busy));
        chk("oDONE", 32'(oDONE), 32'(e_done));
`ifndef FIFO_STIM_SIMUL_EN
        chk("no_simul", 32'(oENQ & oDEQ), 32'd0);
`endif
        if (oENQ && oDEQ) sim_cnt++;
        if (oDONE) done_cnt++;
        pe   = oENQ;
        pd   = oDEQ;
        pdat = oD;
        @(posedge clk);
        #1;
        if (e_enq && !iFULL) exp_d = (exp_d + 1) % 256;
        if (pd && !iEMPTY) begin
            v = q.pop_front();
            chk("deq_data", 32'(v), 32'(exp_rd));
            exp_rd = (exp_rd + 1) % 256;
        end
        if (pe && !iFULL) q.push_back(int'(pdat));
        iFULL  = (q.size() >= S);
        iEMPTY = (q.size() == 0);
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic run_pos(input int pos);
        bit en;
        bit de;
        if (pos < FL) begin
            cyc(1'b1, 1'b0, 1, 1'b1, 1'b0);
        end else if (pos < 2 * FL) begin
            cyc(1'b0, 1'b1, 2, 1'b1, 1'b0);
        end else if (pos < RUN_LEN) begin
            ref_lfsr = ref_step(ref_lfsr);
            en = ref_lfsr[0];
            de = !ref_lfsr[0];
`ifdef FIFO_STIM_SIMUL_EN
            if (ref_lfsr[1:0] == 2'b11) begin
                en = 1'b1;
                de = 1'b1;
            end
`endif
            cyc(en, de, 3, 1'b1, 1'b0);
        end else begin
            cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
        end
    endtask

    task automatic model_reset();
        exp_d    = 0;
        exp_rd   = 0;
        ref_lfsr = SEED;
        q.delete();
        iFULL    = 1'b0;
        iEMPTY   = 1'b1;
    endtask

    initial begin
        reset   = 1'b1;
        iSTART  = 1'b0;
        sim_cnt = 0;
        model_reset();

        // reset held, then quiet idle
        repeat (3) idle_cyc();
        reset = 1'b0;
        repeat (10) idle_cyc();

        // single start pulse, full run
        iSTART = 1'b1;
        idle_cyc();
        iSTART = 1'b0;
        done_cnt = 0;
        for (int p = 0; p <= RUN_LEN; p++) run_pos(p);
        chk("done_once", 32'(done_cnt), 32'd1);
        repeat (2) idle_cyc();

        // reset asserted in the 5th DRAIN cycle
        iSTART = 1'b1;
        idle_cyc();
        iSTART = 1'b0;
        for (int p = 0; p < FL + 4; p++) run_pos(p);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_enq", 32'(oENQ), 32'd0);
        chk("rst_deq", 32'(oDEQ), 32'd0);
        chk("rst_d", 32'(oD), 32'd0);
        chk("rst_phase", 32'(oPHASE), 32'd0);
        chk("rst_busy", 32'(oBUSY), 32'd0);
        chk("rst_done", 32'(oDONE), 32'd0);
        model_reset();
        idle_cyc();
        reset = 1'b0;
        repeat (2) idle_cyc();

        // fresh run after mid-phase reset starts at oD=0
        iSTART = 1'b1;
        idle_cyc();
        iSTART = 1'b0;
        done_cnt = 0;
        for (int p = 0; p <= RUN_LEN; p++) run_pos(p);
        chk("done_once_2", 32'(done_cnt), 32'd1);
        idle_cyc();

        // start held high: back-to-back runs, LFSR continues
        iSTART = 1'b1;
        idle_cyc();
        done_cnt = 0;
        for (int p = 0; p <= RUN_LEN; p++) run_pos(p);
        idle_cyc();
        for (int p = 0; p <= RUN_LEN; p++) run_pos(p);
        iSTART = 1'b0;
        chk("done_twice", 32'(done_cnt), 32'd2);
        repeat (3) idle_cyc();

`ifdef FIFO_STIM_SIMUL_EN
        chk("simul_seen", 32'(sim_cnt > 0), 32'd1);
`else
        chk("simul_none", 32'(sim_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_stim_gen.md
Name: fifo_stim_gen

Overview:
Synthesizable traffic generator that drives a W-bit, S-deep FIFO's enqueue and dequeue inputs.
- Sits directly upstream of the FIFO under test, which in turn feeds the FIFO checker.
- Runs a fixed three-phase sequence (overfill, overdrain, pseudo-random mix) on each start request.
- Writes strictly sequential data values, so dequeued words must read 0, 1, 2, ... (mod 2^W).

Parameters:
W, 8, data width
S, 16, FIFO depth targeted; fill/drain phases last S+2 cycles
SEED, 16'hACE1, LFSR reset value (nonzero)
MIX_LEN, 64, cycles spent in MIX phase

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
iSTART  input  1  start request; sampled only in IDLE
iFULL  input  1  FIFO full flag
iEMPTY  input  1  FIFO empty flag
oENQ  output  1  enqueue strobe to FIFO (registered)
oDEQ  output  1  dequeue strobe to FIFO (registered)
oD  output  W  enqueue data = write counter (registered)
oPHASE  output  2  0 IDLE/DONE, 1 FILL, 2 DRAIN, 3 MIX
oBUSY  output  1  high in FILL, DRAIN, MIX
oDONE  output  1  one-cycle pulse on completion

Behaviour:
- Reset (async, any time, including mid-phase):
  - state=IDLE; oENQ=oDEQ=0; oD=0; oPHASE=0; oBUSY=0; oDONE=0.
  - Write counter=0; phase cycle counter=0; LFSR=SEED.
- States: IDLE -> FILL -> DRAIN -> MIX -> DONE -> IDLE.
- IDLE: all strobes 0. Goes to FILL on the edge where iSTART=1.
- FILL:
  - oENQ=1, oDEQ=0 for exactly S+2 consecutive cycles. The last two are deliberate overfill attempts.
  - Then DRAIN.
- DRAIN:
  - oDEQ=1, oENQ=0 for exactly S+2 cycles. The last two are deliberate underflow attempts.
  - Then MIX.
- MIX:
  - MIX_LEN cycles. The 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every MIX cycle.
  - LFSR bit0=1 -> oENQ=1, oDEQ=0; bit0=0 -> oDEQ=1, oENQ=0.
  - Then DONE.
- DONE: oDONE=1 for one cycle; strobes 0; then IDLE. iSTART held high restarts on the next IDLE cycle.
- Write counter:
  - Increments (mod 2^W, wraps 255->0 for W=8) on any edge where oENQ=1 and iFULL=0.
  - Does not increment when iFULL=1, so rejected writes do not create data gaps.
  - oD always equals the counter.
- Phase cycle counter width: $clog2(max(S+2, MIX_LEN)+1). Clears on every phase entry.
- iEMPTY:
  - Has no effect on sequencing.
  - Drives one internal sticky error bit: set if oDEQ=1 while iEMPTY=1 outside DRAIN's last 2 cycles. Cleared by reset or by IDLE->FILL.
- oENQ and oDEQ are mutually exclusive unless the optional feature is enabled.
- All state changes take one clk edge. Strobes reflect the state registered on the previous edge; zero combinational input->output paths.

Optional Feature:
FIFO_STIM_SIMUL_EN:
- Defined:
  - In MIX, LFSR bits[1:0]==2'b11 asserts oENQ=1 and oDEQ=1 together.
  - Otherwise bit0 selects as above.
  - The write counter still follows the oENQ && !iFULL rule.
- Undefined: strobes are never simultaneous. The RTL must contain zero logic for the 2'b11 case.

Decomposition:
- Shared package fifo_stim_pkg:
  - State enum localparams: IDLE=3'd0, FILL=3'd1, DRAIN=3'd2, MIX=3'd3, DONE=3'd4.
  - PHASE encodings.
  - LFSR tap mask 16'hB400.
  - Default SEED.
- One natural sub-module: lfsr16 (clk, reset, enable, seed, q[15:0]), instantiated once.

Test Plan:
1. Reset held 3 cycles, release, iSTART=0 for 10 cycles -> oENQ=oDEQ=0, oD=0, oPHASE=0, oBUSY=0 throughout.
2. iSTART pulse, FIFO model S=16 -> 18 FILL cycles with oENQ=1; oD runs 0..15 then holds 16 while iFULL=1; oPHASE=1; 18 DRAIN cycles follow.
3. Full run with model, W=8, MIX_LEN=300 -> dequeued words are consecutive mod 256, including the 255->0 wrap; oDONE pulses exactly once, 18+18+300+1 cycles after start.
4. Reset asserted on cycle 5 of DRAIN -> next edge all outputs 0, state IDLE; a new iSTART gives oD starting at 0.
5. MIX, macro undefined -> oENQ&oDEQ never 1 across 1000 cycles. Macro defined -> at least one simultaneous cycle; counter steps by 1 on that cycle when iFULL=0.
6. iSTART held high continuously -> back-to-back runs separated by one DONE and one IDLE cycle; LFSR continues from its prior value rather than reloading SEED.
